// File: rtl/rev_arbiter_pkg.sv
// Shared types and default sizing for the rev_arbiter block.
package rev_arbiter_pkg;

  // Default log2 of the payload width (payload is 2**N bits).
  localparam int unsigned N_DEFAULT = 3;
  // Default number of requesters.
  localparam int unsigned R_DEFAULT = 4;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search req valids starting at ptr, wrapping R-1 -> 0.
module rr_arbiter #(
  parameter int unsigned R = 4,
  localparam int unsigned IW = $clog2(R)
) (
  input  logic [R-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // First valid requester at or after ptr wins; ptr is always < R.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < R; k++) begin
      cand = IW'((32'(ptr) + k) % R);
      if (!any && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rev_arbiter.sv
// Round-robin arbiter with a one-deep output register and optional
// per-requester bit reversal of the payload.
// Optional feature: define REV_ARBITER_STATS_EN to add the 16-bit
// xfer_count output counting accepted output transfers.
module rev_arbiter
  import rev_arbiter_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned R = R_DEFAULT,
  localparam int unsigned W  = 2 ** N,
  localparam int unsigned IW = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [R-1:0]  req_valid,
  input  logic [R*W-1:0] req_data,
  input  logic [R-1:0]  req_rev,
  output logic [R-1:0]  req_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_id,
  input  logic          out_ready
`ifdef REV_ARBITER_STATS_EN
  ,
  output logic [15:0]   xfer_count
`endif
);

  state_t        state;
  logic [IW-1:0] ptr;

  logic [R-1:0]  grant;
  logic [IW-1:0] win_idx;
  logic          win_any;

  logic          can_accept_c;
  logic          xfer_c;
  logic [W-1:0]  sel_data;
  logic          sel_rev;
  logic [W-1:0]  rev_data;
  logic [W-1:0]  cap_data;

  rr_arbiter #(.R(R)) u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Register can take new data when empty or being drained this cycle.
  always_comb begin
    can_accept_c = !rst && ((state == EMPTY) || out_ready);
    req_ready    = can_accept_c ? grant : '0;
    xfer_c       = can_accept_c && win_any;
  end

  // Route the winning payload and its reverse flag.
  always_comb begin
    sel_data = '0;
    sel_rev  = 1'b0;
    for (int unsigned i = 0; i < R; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*W +: W];
        sel_rev  = req_rev[i];
      end
    end
  end

  // Bit reversal of the selected payload.
  always_comb begin
    rev_data = '0;
    for (int unsigned k = 0; k < W; k++) begin
      rev_data[W-1-k] = sel_data[k];
    end
    cap_data = sel_rev ? rev_data : sel_data;
  end

  // Occupancy FSM, output register and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_id   <= '0;
      ptr      <= '0;
    end else if (xfer_c) begin
      state    <= FULL;
      out_data <= cap_data;
      out_id   <= win_idx;
      ptr      <= (win_idx == IW'(R - 1)) ? '0 : win_idx + IW'(1);
    end else if ((state == FULL) && out_ready) begin
      state    <= EMPTY;
    end
  end

  assign out_valid = (state == FULL);

`ifdef REV_ARBITER_STATS_EN
  // Count accepted output transfers, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rev_arbiter.sv
// Self-checking bench for rev_arbiter (R=4, W=8) with a behavioural model.
module tb_rev_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned R  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R-1:0]   req_valid = '0;
  logic [R*W-1:0] req_data = '0;
  logic [R-1:0]   req_rev = '0;
  logic [R-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           out_ready = 1'b0;
`ifdef REV_ARBITER_STATS_EN
  logic [15:0]    xfer_count;
`endif

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: what the output register must hold.
  bit          m_valid = 1'b0;
  logic [7:0]  m_data = '0;
  int          m_id = 0;
  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;

  rev_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_rev   (req_rev),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef REV_ARBITER_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Winner index by round-robin from ptr, or -1 if nobody is valid.
  function automatic int winner(input logic [R-1:0] v, input int p);
    for (int k = 0; k < R; k++) begin
      if (v[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  function automatic logic [R-1:0] exp_ready();
    int w;
    logic [R-1:0] g;
    g = '0;
    w = winner(req_valid, m_ptr);
    if (!rst && !(m_valid && !out_ready) && w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  // Behavioural model: advance on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    int w;
    logic [7:0] p;
    logic [7:0] pr;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 0;
      m_ptr   <= 0;
      m_cnt   <= '0;
    end else begin
      w = winner(req_valid, m_ptr);
      if (m_valid && out_ready) m_cnt <= m_cnt + 16'd1;
      if (!(m_valid && !out_ready) && w >= 0) begin
        p  = req_data[w*W +: W];
        pr = {<<{p}};
        m_valid <= 1'b1;
        m_data  <= req_rev[w] ? pr : p;
        m_id    <= w;
        m_ptr   <= (w + 1) % R;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process: outputs against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_id", 32'(out_id), 32'(m_id));
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready()));
`ifdef REV_ARBITER_STATS_EN
      chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
    end
  end

  // Advance one cycle; inputs change shortly after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset, with requests pending: no grant while rst is high.
    req_valid = 4'b1111;
    tick();
    #1 chk("ready_in_rst", 32'(req_ready), 32'h0);
    tick();
    req_valid = '0;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);

    // Single request, reversed: 0x01 -> 0x80.
    req_valid = 4'b0001;
    req_data  = 32'h0000_0001;
    req_rev   = 4'b0001;
    out_ready = 1'b1;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'h80);
    chk("single_id", 32'(out_id), 32'h0);

    // Pass-through path.
    req_data = 32'h0000_00B4;
    req_rev  = 4'b0000;
    tick();
    chk("pass_data", 32'(out_data), 32'hB4);

    // Fairness: all valid, consumer always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_id", 32'(out_id), 32'(k % 4));
    end

    // Backpressure: holding id 0 / 0x11.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", 32'(req_ready), 32'h0);
      tick();
      chk("stall_data", 32'(out_data), 32'h11);
      chk("stall_id", 32'(out_id), 32'h0);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 32'(req_ready), 32'h2);
    tick();
    chk("release_valid", 32'(out_valid), 32'h1);
    chk("release_id", 32'(out_id), 32'h1);
    chk("release_data", 32'(out_data), 32'h22);

    // Reset during a stall.
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1 chk("rst_stall_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    chk("rst_stall_valid", 32'(out_valid), 32'h0);
    req_valid = 4'b1010;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    chk("post_rst_id", 32'(out_id), 32'h1);
    chk("post_rst_data", 32'(out_data), 32'h22);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      req_data  = $urandom;
      req_rev   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

`ifdef REV_ARBITER_STATS_EN
    // Counter wrap: 65537 drains leave a count of 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (65538) tick();
    chk("stats_wrap", 32'(xfer_count), 32'h1);
`endif

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rev_arbiter.md
REV_ARBITER -- requirements
Module: rev_arbiter

Interface
REQ-001 SHALL have parameter N, default 3, log2 of the data width; W = 2**N.
REQ-002 SHALL have parameter R, default 4, the number of requesters (2..8); IW = $clog2(R).
REQ-003 SHALL have port clk, input, width 1: single clock, all logic on the rising edge.
REQ-004 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, width R: requester i has a transfer pending.
REQ-006 SHALL have port req_data, input, width R x W: payload for each requester.
REQ-007 SHALL have port req_rev, input, width R: 1 = bit-reverse the payload, 0 = pass it through.
REQ-008 SHALL have port req_ready, output, width R: one-hot grant; a transfer on i completes when req_valid[i] & req_ready[i].
REQ-009 SHALL have port out_valid, output, width 1: the output register holds a result.
REQ-010 SHALL have port out_data, output, width W: the result, with out_data[W-1-k] = payload[k] when rev = 1.
REQ-011 SHALL have port out_id, output, width IW: index of the requester that produced out_data.
REQ-012 SHALL have port out_ready, input, width 1: the consumer accepts the result when out_valid & out_ready.

Function
REQ-013 SHALL keep a single output register and a two-state FSM: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-014 SHALL treat the output register as able to accept data when the state is EMPTY, or when it is FULL with out_ready = 1.
REQ-015 SHALL assert req_ready only when the output register can accept data, and then on exactly one valid requester; req_ready SHALL be all-zero when no requester is valid.
REQ-016 SHALL select the winner round-robin: the search starts at priority pointer ptr and wraps from R-1 to 0.
REQ-017 SHALL set ptr = (winner+1) mod R after each accepted transfer; ptr SHALL be unchanged when there is no grant.
REQ-018 SHALL, on grant, capture the reversed or passed-through payload and the winner index, and present them in the next cycle (latency 1).
REQ-019 SHALL handle drain and grant in the same cycle (FULL & out_ready & a grant) by staying FULL with the new data; there SHALL be no bubble.
REQ-020 SHALL move FULL -> EMPTY on out_ready with no grant, and EMPTY -> FULL on a grant.
REQ-021 SHALL, while FULL and stalled (out_ready = 0), hold out_data and out_id stable and keep req_ready = 0.
REQ-022 SHALL be combinational from req_valid to req_ready, and SHALL NOT depend combinationally on req_data.
REQ-023 SHALL NOT let a requester that drops req_valid before its grant affect ptr.

Reset
REQ-024 SHALL, on rst = 1 at a clock edge, set state = EMPTY, out_valid = 0, out_data = 0, out_id = 0 and ptr = 0.
REQ-025 SHALL discard any held result when rst is asserted mid-operation, and SHALL drive req_ready = 0 during the rst cycle.

Configuration
REQ-026 SHALL, when macro REV_ARBITER_STATS_EN is defined, add output xfer_count (width 16).
REQ-027 SHALL increment xfer_count on each accepted output transfer, wrap from 0xFFFF to 0, and reset it to 0.
REQ-028 SHALL, without REV_ARBITER_STATS_EN, have neither the port nor the counter logic; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL place in package rev_arbiter_pkg: the state enum typedef (EMPTY, FULL) and the default constants for N and R.
REQ-030 SHALL put the round-robin grant logic (req_valid, ptr -> one-hot grant, winner index) in sub-module rr_arbiter, parameterised by R.
REQ-031 SHALL implement the bit reversal as an inline loop; it SHALL NOT be a separate state element.

Verification
REQ-032 SHALL cover a single request: R=4, req_valid=0001, data 0x01, rev=1, out_ready=1 -> next cycle out_valid=1, out_data=0x80, out_id=0.
REQ-033 SHALL cover the pass-through path: data 0xB4, rev=0 -> out_data=0xB4.
REQ-034 SHALL cover round-robin fairness: req_valid=1111 held, out_ready=1 -> out_id sequence 0,1,2,3,0 with one result every cycle.
REQ-035 SHALL cover backpressure: out_ready=0 for 3 cycles while FULL -> req_ready=0000 and out_data stable; on release, drain and new grant happen in the same cycle.
REQ-036 SHALL cover reset mid-stall: rst=1 while FULL -> next cycle out_valid=0, ptr=0, and the next grant goes to the lowest valid index.
REQ-037 SHALL cover the stats option, with REV_ARBITER_STATS_EN defined: 65537 transfers -> xfer_count=1.
